// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the memory-reference control sequencer:
// instruction opcodes, ALU opcode, state encoding and the control word.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;

  typedef enum logic [4:0] {
    S_IDLE = 5'd0,
    S_F0   = 5'd1,
    S_F1   = 5'd2,
    S_F2   = 5'd3,
    S_LD3  = 5'd4,
    S_LD4  = 5'd5,
    S_LD5  = 5'd6,
    S_LD6  = 5'd7,
    S_LD7  = 5'd8,
    S_LDI3 = 5'd9,
    S_LDI4 = 5'd10,
    S_LDI5 = 5'd11,
    S_ST3  = 5'd12,
    S_ST4  = 5'd13,
    S_ST5  = 5'd14,
    S_ST6  = 5'd15,
    S_ST7  = 5'd16,
    S_HALT = 5'd17
  } state_e;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       c_out;
    logic       ba_out;
    logic       r_out;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       zlow_in;
    logic       r_in;
    logic       inc_pc;
    logic       rd;
    logic       wr;
    logic       gra;
    logic       grb;
    logic [4:0] opcode;
    logic [3:0] t_step;
    logic       run;
  } ctrl_word_t;

endpackage

// File: rtl/mem_ctrl_seq_if.sv
// Sequencer <-> DataPath bundle: instruction/handshake inputs and the
// per-step control strobes. master = sequencer, slave = DataPath side.
interface mem_ctrl_seq_if;
  logic [31:0] IR;
  logic        mem_rdy;
  logic        stop;
  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin;
  logic        IncPC, Read, Write, Gra, Grb;
  logic [4:0]  opcode;
  logic        run;
  logic        illegal_op;
  logic [3:0]  t_step;

  modport master (
    input  IR, mem_rdy, stop,
    output PCout, Zlowout, MDRout, Cout, BAout, Rout,
           MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin,
           IncPC, Read, Write, Gra, Grb, opcode, run, illegal_op, t_step
  );

  modport slave (
    output IR, mem_rdy, stop,
    input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
           MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin,
           IncPC, Read, Write, Gra, Grb, opcode, run, illegal_op, t_step
  );
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: maps the sequencer state to its control word.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t cw_o
);

  // Every strobe defaults low; each state raises only its own set.
  always_comb begin
    cw_o     = '0;
    cw_o.run = (state_i != S_IDLE) && (state_i != S_HALT);
    case (state_i)
      S_F0: begin
        cw_o.pc_out = 1'b1; cw_o.mar_in = 1'b1; cw_o.inc_pc = 1'b1; cw_o.zlow_in = 1'b1;
        cw_o.t_step = 4'd0;
      end
      S_F1: begin
        cw_o.zlow_out = 1'b1; cw_o.pc_in = 1'b1; cw_o.rd = 1'b1; cw_o.mdr_in = 1'b1;
        cw_o.t_step = 4'd1;
      end
      S_F2: begin
        cw_o.mdr_out = 1'b1; cw_o.ir_in = 1'b1;
        cw_o.t_step = 4'd2;
      end
      S_LD3, S_LDI3, S_ST3: begin
        cw_o.grb = 1'b1; cw_o.ba_out = 1'b1; cw_o.y_in = 1'b1;
        cw_o.t_step = 4'd3;
      end
      S_LD4, S_LDI4, S_ST4: begin
        cw_o.c_out = 1'b1; cw_o.opcode = ALU_ADD; cw_o.zlow_in = 1'b1;
        cw_o.t_step = 4'd4;
      end
      S_LD5, S_ST5: begin
        cw_o.zlow_out = 1'b1; cw_o.mar_in = 1'b1;
        cw_o.t_step = 4'd5;
      end
      S_LDI5: begin
        cw_o.zlow_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
        cw_o.t_step = 4'd5;
      end
      S_LD6: begin
        cw_o.rd = 1'b1; cw_o.mdr_in = 1'b1;
        cw_o.t_step = 4'd6;
      end
      S_ST6: begin
        cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.mdr_in = 1'b1;
        cw_o.t_step = 4'd6;
      end
      S_LD7: begin
        cw_o.mdr_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
        cw_o.t_step = 4'd7;
      end
      S_ST7: begin
        cw_o.wr = 1'b1;
        cw_o.t_step = 4'd7;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_ctrl_seq.sv
// Hardwired fetch / ld / ldi / st control sequencer (Moore FSM).
// Optional build macro: MEM_WAIT_EN -- F1, LD6 and ST7 stall until mem_rdy.
//
// state | meaning
// IDLE  | out of reset, no sequencing
// F0-F2 | instruction fetch, branch on opcode after F2
// LDx   | ld address calc, memory read, register write
// LDIx  | ldi address calc, register write
// STx   | st address calc, data stage, memory write
// HALT  | stopped; sticky when entered via the halt opcode
module mem_ctrl_seq
  import cpu_ctrl_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  mem_ctrl_seq_if.master bus
);

  state_e     state_q, state_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;
  logic       mem_go;
  logic [4:0] ir_op;
  logic       unused_in_bits;
  ctrl_word_t cw;

  assign ir_op = bus.IR[IR_OP_HI:IR_OP_LO];

`ifdef MEM_WAIT_EN
  assign mem_go         = bus.mem_rdy;
  assign unused_in_bits = ^bus.IR[IR_OP_LO-1:0];
`else
  assign mem_go         = 1'b1;
  assign unused_in_bits = ^{bus.IR[IR_OP_LO-1:0], bus.mem_rdy};
`endif

  // State register, sticky halt-by-opcode flag and the one-cycle illegal pulse.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: linear step chains, opcode branch after F2, stop at boundaries.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   if (mem_go) state_d = S_F2;
      S_F2: begin
        case (ir_op)
          OP_LD:   state_d = S_LD3;
          OP_LDI:  state_d = S_LDI3;
          OP_ST:   state_d = S_ST3;
          OP_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: begin
            state_d   = S_F0;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_LD3:  state_d = S_LD4;
      S_LD4:  state_d = S_LD5;
      S_LD5:  state_d = S_LD6;
      S_LD6:  if (mem_go) state_d = S_LD7;
      S_LD7:  state_d = bus.stop ? S_HALT : S_F0;
      S_LDI3: state_d = S_LDI4;
      S_LDI4: state_d = S_LDI5;
      S_LDI5: state_d = bus.stop ? S_HALT : S_F0;
      S_ST3:  state_d = S_ST4;
      S_ST4:  state_d = S_ST5;
      S_ST5:  state_d = S_ST6;
      S_ST6:  state_d = S_ST7;
      S_ST7:  if (mem_go) state_d = bus.stop ? S_HALT : S_F0;
      S_HALT: if (!halted_q && !bus.stop) state_d = S_F0;
      default: state_d = S_IDLE;
    endcase
  end

  ctrl_decode u_decode (
    .state_i (state_q),
    .cw_o    (cw)
  );

  assign bus.PCout      = cw.pc_out;
  assign bus.Zlowout    = cw.zlow_out;
  assign bus.MDRout     = cw.mdr_out;
  assign bus.Cout       = cw.c_out;
  assign bus.BAout      = cw.ba_out;
  assign bus.Rout       = cw.r_out;
  assign bus.MARin      = cw.mar_in;
  assign bus.PCin       = cw.pc_in;
  assign bus.MDRin      = cw.mdr_in;
  assign bus.IRin       = cw.ir_in;
  assign bus.Yin        = cw.y_in;
  assign bus.ZLowIn     = cw.zlow_in;
  assign bus.Rin        = cw.r_in;
  assign bus.IncPC      = cw.inc_pc;
  assign bus.Read       = cw.rd;
  assign bus.Write      = cw.wr;
  assign bus.Gra        = cw.gra;
  assign bus.Grb        = cw.grb;
  assign bus.opcode     = cw.opcode;
  assign bus.t_step     = cw.t_step;
  assign bus.run        = cw.run;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// Testbench for mem_ctrl_seq: per-cycle comparison of all outputs against a
// step-table model of the instruction sequences. Honours MEM_WAIT_EN.
module tb_mem_ctrl_seq;

  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_HALT = 3, K_BAD = 4;
  localparam int B_PCOUT = 0, B_ZLOWOUT = 1, B_MDROUT = 2, B_COUT = 3, B_BAOUT = 4,
                 B_ROUT = 5, B_MARIN = 6, B_PCIN = 7, B_MDRIN = 8, B_IRIN = 9,
                 B_YIN = 10, B_ZLOWIN = 11, B_RIN = 12, B_INCPC = 13, B_READ = 14,
                 B_WRITE = 15, B_GRA = 16, B_GRB = 17;

  logic clk;
  logic clear;
  int   vectors;
  int   miscompares;
  bit   exp_ill;

  mem_ctrl_seq_if bus ();

  mem_ctrl_seq dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [28:0] obs();
    logic [17:0] s;
    s = '0;
    s[B_PCOUT] = bus.PCout;   s[B_ZLOWOUT] = bus.Zlowout; s[B_MDROUT] = bus.MDRout;
    s[B_COUT]  = bus.Cout;    s[B_BAOUT]   = bus.BAout;   s[B_ROUT]   = bus.Rout;
    s[B_MARIN] = bus.MARin;   s[B_PCIN]    = bus.PCin;    s[B_MDRIN]  = bus.MDRin;
    s[B_IRIN]  = bus.IRin;    s[B_YIN]     = bus.Yin;     s[B_ZLOWIN] = bus.ZLowIn;
    s[B_RIN]   = bus.Rin;     s[B_INCPC]   = bus.IncPC;   s[B_READ]   = bus.Read;
    s[B_WRITE] = bus.Write;   s[B_GRA]     = bus.Gra;     s[B_GRB]    = bus.Grb;
    return {s, bus.opcode, bus.t_step, bus.run, bus.illegal_op};
  endfunction

  function automatic logic [28:0] exp_vec(input int kind, input int step, input bit ill);
    logic [17:0] s;
    s = '0;
    case (step)
      0: begin s[B_PCOUT] = 1; s[B_MARIN] = 1; s[B_INCPC] = 1; s[B_ZLOWIN] = 1; end
      1: begin s[B_ZLOWOUT] = 1; s[B_PCIN] = 1; s[B_READ] = 1; s[B_MDRIN] = 1; end
      2: begin s[B_MDROUT] = 1; s[B_IRIN] = 1; end
      3: begin s[B_GRB] = 1; s[B_BAOUT] = 1; s[B_YIN] = 1; end
      4: begin s[B_COUT] = 1; s[B_ZLOWIN] = 1; end
      5: begin
        s[B_ZLOWOUT] = 1;
        if (kind == K_LDI) begin s[B_GRA] = 1; s[B_RIN] = 1; end
        else s[B_MARIN] = 1;
      end
      6: begin
        s[B_MDRIN] = 1;
        if (kind == K_LD) s[B_READ] = 1;
        else begin s[B_GRA] = 1; s[B_ROUT] = 1; end
      end
      7: begin
        if (kind == K_LD) begin s[B_MDROUT] = 1; s[B_GRA] = 1; s[B_RIN] = 1; end
        else s[B_WRITE] = 1;
      end
      default: ;
    endcase
    return {s, (step == 4) ? 5'b00011 : 5'b00000, 4'(step), 1'b1, ill};
  endfunction

  function automatic int kind_of(input logic [4:0] op);
    case (op)
      5'b00000: return K_LD;
      5'b00001: return K_LDI;
      5'b00010: return K_ST;
      5'b11011: return K_HALT;
      default:  return K_BAD;
    endcase
  endfunction

  function automatic int last_step(input int kind);
    case (kind)
      K_LD, K_ST: return 7;
      K_LDI:      return 5;
      default:    return 2;
    endcase
  endfunction

  function automatic bit is_wait(input int kind, input int step);
    return (step == 1) || (kind == K_LD && step == 6) || (kind == K_ST && step == 7);
  endfunction

  // Runs one instruction starting from F0 (sampled at a negedge) and checks every cycle.
  task automatic exec_instr(input string tag, input logic [31:0] ir, input bit stop_b,
                            input int stop_step, input bit rand_stall, input int st7_stalls,
                            input int abort_step, output int write_cycles);
    int kind, step, stalls, st7_left;
    bit rdy, ill0;
    logic [28:0] e, o;
    kind = kind_of(ir[31:27]);
    bus.IR = ir;
    bus.stop = 1'b0;
    step = 0; stalls = 0; st7_left = st7_stalls; write_cycles = 0;
    ill0 = exp_ill;
    exp_ill = 1'b0;
    while (step <= last_step(kind)) begin
      rdy = 1'b1;
      if (kind == K_ST && step == 7 && st7_left > 0) begin
        rdy = 1'b0; st7_left--;
      end else if (rand_stall && is_wait(kind, step) && stalls < 8 && $urandom_range(0, 2) == 0) begin
        rdy = 1'b0; stalls++;
      end
      bus.mem_rdy = rdy;
      e = exp_vec(kind, step, ill0 && step == 0);
      o = obs();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s: IR=%h step %0d outputs got %h expected %h", tag, bus.IR, step, o, e);
      end
      if (bus.Write === 1'b1) write_cycles++;
      if (step == abort_step) begin
        #1 clear = 1'b0;
        #1;
        vectors++;
        if (obs() !== 29'b0) begin
          miscompares++;
          $display("FAIL %s_async_clear: outputs got %h expected %h", tag, obs(), 29'b0);
        end
        bus.mem_rdy = 1'b1;
        return;
      end
      if (step == stop_step) bus.stop = stop_b;
      @(posedge clk); @(negedge clk);
`ifdef MEM_WAIT_EN
      if (!(is_wait(kind, step) && !rdy)) step++;
`else
      step++;
`endif
    end
    exp_ill = (kind == K_BAD);
    bus.mem_rdy = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b0; bus.IR = '0; bus.stop = 1'b0; bus.mem_rdy = 1'b1; exp_ill = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs() !== 29'b0) begin
        miscompares++;
        $display("FAIL reset_hold: outputs got %h expected %h", obs(), 29'b0);
      end
      @(negedge clk);
    end
    clear = 1'b1;
    #1;
    vectors++;
    if (obs() !== 29'b0) begin
      miscompares++;
      $display("FAIL reset_idle: outputs got %h expected %h", obs(), 29'b0);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_ld();
    int wc;
    exec_instr("ld", 32'h01000095, 1'b0, -1, 1'b0, 0, -1, wc);
  endtask

  task automatic test_ldi();
    int wc;
    exec_instr("ldi", 32'h09800005, 1'b0, -1, 1'b0, 0, -1, wc);
  endtask

  task automatic test_st();
    int wc;
    exec_instr("st", 32'h10900087, 1'b0, -1, 1'b0, 0, -1, wc);
    vectors++;
    if (wc !== 1) begin
      miscompares++;
      $display("FAIL st_write_cycles: got %0d expected 1", wc);
    end
  endtask

  task automatic test_illegal();
    int wc;
    exec_instr("illegal", 32'hF8000000, 1'b0, -1, 1'b0, 0, -1, wc);
    exec_instr("after_illegal", 32'h01000095, 1'b0, -1, 1'b0, 0, -1, wc);
  endtask

  task automatic test_st_wait_stop();
    int wc, exp_wc;
`ifdef MEM_WAIT_EN
    exp_wc = 4;
`else
    exp_wc = 1;
`endif
    exec_instr("st_wait", 32'h10900087, 1'b1, 7, 1'b0, 3, -1, wc);
    vectors++;
    if (wc !== exp_wc) begin
      miscompares++;
      $display("FAIL st_wait_write_cycles: got %0d expected %0d", wc, exp_wc);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs() !== 29'b0) begin
        miscompares++;
        $display("FAIL st_wait_halt: outputs got %h expected %h", obs(), 29'b0);
      end
      @(posedge clk); @(negedge clk);
    end
    bus.stop = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_stop_ld();
    int wc;
    exec_instr("stop_ld", 32'h01000095, 1'b1, 4, 1'b0, 0, -1, wc);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs() !== 29'b0) begin
        miscompares++;
        $display("FAIL stop_ld_halt: outputs got %h expected %h", obs(), 29'b0);
      end
      @(posedge clk); @(negedge clk);
    end
    bus.stop = 1'b0;
    @(posedge clk); @(negedge clk);
    exec_instr("resume_ldi", 32'h09800005, 1'b0, -1, 1'b0, 0, -1, wc);
  endtask

  task automatic test_halt_op();
    int wc;
    exec_instr("halt_op", 32'hD8000000, 1'b0, -1, 1'b0, 0, -1, wc);
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (obs() !== 29'b0) begin
        miscompares++;
        $display("FAIL halt_op_sticky: cycle %0d outputs got %h expected %h", n, obs(), 29'b0);
      end
      bus.stop = n[0];
      @(posedge clk); @(negedge clk);
    end
    bus.stop = 1'b0;
    clear = 1'b0;
    #1;
    vectors++;
    if (obs() !== 29'b0) begin
      miscompares++;
      $display("FAIL halt_op_clear: outputs got %h expected %h", obs(), 29'b0);
    end
    @(negedge clk);
    clear = 1'b1;
    #1;
    vectors++;
    if (obs() !== 29'b0) begin
      miscompares++;
      $display("FAIL halt_op_idle: outputs got %h expected %h", obs(), 29'b0);
    end
    exp_ill = 1'b0;
    @(posedge clk); @(negedge clk);
    exec_instr("after_halt_op", 32'h01000095, 1'b0, -1, 1'b0, 0, -1, wc);
  endtask

  task automatic test_reset_mid();
    int wc;
    exec_instr("reset_mid", 32'h01000095, 1'b0, -1, 1'b0, 0, 6, wc);
    @(negedge clk);
    clear = 1'b1;
    #1;
    vectors++;
    if (obs() !== 29'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: outputs got %h expected %h", obs(), 29'b0);
    end
    exp_ill = 1'b0;
    @(posedge clk); @(negedge clk);
    exec_instr("after_reset_mid", 32'h10900087, 1'b0, -1, 1'b0, 0, -1, wc);
  endtask

  task automatic test_random();
    int wc, k, last, sstep;
    logic [4:0] op;
    logic [31:0] ir;
    bit stopb;
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 4));
      case (k)
        0: op = 5'b00000;
        1: op = 5'b00001;
        2: op = 5'b00010;
        default: begin
          op = 5'(($urandom_range(3, 31)));
          if (op == 5'b11011) op = 5'b11100;
        end
      endcase
      ir = {op, 27'($urandom)};
      last = last_step(kind_of(op));
      stopb = (k < 3) && ($urandom_range(0, 4) == 0);
      sstep = stopb ? int'($urandom_range(0, last)) : -1;
      exec_instr("random", ir, stopb, sstep, 1'b1, 0, -1, wc);
      if (stopb) begin
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs() !== 29'b0) begin
            miscompares++;
            $display("FAIL random_halt: outputs got %h expected %h", obs(), 29'b0);
          end
          @(posedge clk); @(negedge clk);
        end
        bus.stop = 1'b0;
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_ld();
    test_ldi();
    test_st();
    test_illegal();
    test_st_wait_stop();
    test_stop_ld();
    test_halt_op();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
